sysid_check_master: RTL and testbench

// - Avalon-MM read master that interrogates the system-ID slave at start-up and on demand.
// - Reads ID word (word offset 0), then timestamp word (offset 1), and compares both with

---
 rtl/sysid_check_pkg.sv | 21 ++
 rtl/sysid_check_master_if.sv | 28 ++
 rtl/sysid_check_timer.sv | 36 +++
 rtl/sysid_check_master.sv | 141 ++++++++++++++
 tb/tb_sysid_check_master.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
// State encoding, sysid word offsets and default build-time expected values.
package sysid_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ID_REQ  = 3'd1,
      ST_ID_WAIT = 3'd2,
      ST_TS_REQ  = 3'd3,
      ST_TS_WAIT = 3'd4,
      ST_FIN     = 3'd5
   } state_e;

   localparam int OFF_ID  = 0;
   localparam int OFF_TS  = 1;
   localparam int TIMER_W = 16;

   localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] DEF_EXPECTED_TS = 32'h5593_1994;

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only bus between the check master and the system-ID slave.
interface sysid_check_master_if #(
   parameter int ADDR_W = 1
);

   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest;
   logic [31:0]       avm_readdata;
   logic              avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/sysid_check_timer.sv
// Per-read cycle budget counter: cleared when a read begins, counts while enabled,
// and flags the last allowed cycle so the FSM can abandon the read.
module sysid_check_timer
   import sysid_check_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               enable,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired
);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Count k-1 is visible in the k-th cycle of a read, so this fires on cycle 'limit'.
   assign expired = enable && (count_q == (limit - TIMER_W'(1)));

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares them
// against build-time values, reporting sticky done/pass status to board logic.
module sysid_check_master
   import sysid_check_pkg::*;
#(
   parameter int          ADDR_W      = 1,
   parameter int          BASE_WORD   = 0,
   parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
   parameter int          TIMEOUT_CYC = 255,
   parameter bit          AUTO_START  = 1'b1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   sysid_check_master_if.master        avm,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        id_ok,
   output logic                        ts_ok,
   output logic                        timeout,
   output logic [31:0]                 id_value,
   output logic [31:0]                 ts_value
);

   localparam logic [ADDR_W-1:0]  ADDR_ID     = ADDR_W'(BASE_WORD + OFF_ID);
   localparam logic [ADDR_W-1:0]  ADDR_TS     = ADDR_W'(BASE_WORD + OFF_TS);
   localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYC);

   state_e            state_q, state_d;
   logic              autoPend_q, startPend_q;
   logic              done_q, pass_q, idOk_q, tsOk_q, timeout_q;
   logic [31:0]       idValue_q, tsValue_q;
   logic              inReq, inWait, accept, dataValid, startCheck, readAbort;
   logic              readReq, timerClear, timerEnable, timerExpired;
   logic [ADDR_W-1:0] address;

   assign inReq      = (state_q == ST_ID_REQ)  || (state_q == ST_TS_REQ);
   assign inWait     = (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT);
   assign accept     = inReq && !avm.avm_waitrequest;
   assign dataValid  = inWait && avm.avm_readdatavalid;
   assign startCheck = (state_q == ST_IDLE) && (start || autoPend_q || startPend_q);
   // A read that completes on its last budgeted cycle still counts as a success.
   assign readAbort  = timerExpired && ((inReq && !accept) || (inWait && !dataValid));

   sysid_check_timer u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timerClear),
      .enable  (timerEnable),
      .limit   (TIMER_LIMIT),
      .expired (timerExpired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (startCheck) state_d = ST_ID_REQ;
         ST_ID_REQ:  if (accept) state_d = ST_ID_WAIT; else if (readAbort) state_d = ST_FIN;
         ST_ID_WAIT: if (dataValid) state_d = ST_TS_REQ; else if (readAbort) state_d = ST_FIN;
         ST_TS_REQ:  if (accept) state_d = ST_TS_WAIT; else if (readAbort) state_d = ST_FIN;
         ST_TS_WAIT: if (dataValid || readAbort) state_d = ST_FIN;
         ST_FIN:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Bus outputs decode straight from the state register so reset drops avm_read at once.
   always_comb begin
      readReq     = inReq;
      address     = ((state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT)) ? ADDR_TS : ADDR_ID;
      busy        = (state_q != ST_IDLE);
      timerEnable = inReq || inWait;
      timerClear  = startCheck || ((state_q == ST_ID_WAIT) && dataValid);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         autoPend_q  <= AUTO_START;
         startPend_q <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         idOk_q      <= 1'b0;
         tsOk_q      <= 1'b0;
         timeout_q   <= 1'b0;
         idValue_q   <= '0;
         tsValue_q   <= '0;
      end else begin
         if (state_q == ST_IDLE) begin
            autoPend_q  <= 1'b0;
            startPend_q <= 1'b0;
         end else if ((state_q == ST_FIN) && start) begin
            startPend_q <= 1'b1;
         end
         if (startCheck) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            idOk_q    <= 1'b0;
            tsOk_q    <= 1'b0;
            timeout_q <= 1'b0;
            idValue_q <= '0;
            tsValue_q <= '0;
         end
         if ((state_q == ST_ID_WAIT) && dataValid) begin
            idValue_q <= avm.avm_readdata;
            idOk_q    <= (avm.avm_readdata == EXPECTED_ID);
         end
         if ((state_q == ST_TS_WAIT) && dataValid) begin
            tsValue_q <= avm.avm_readdata;
            tsOk_q    <= (avm.avm_readdata == EXPECTED_TS);
         end
         if (readAbort) begin
            timeout_q <= 1'b1;
         end
         if (state_q == ST_FIN) begin
            done_q <= 1'b1;
            pass_q <= idOk_q && tsOk_q && !timeout_q;
         end
      end
   end

   assign avm.avm_read    = readReq;
   assign avm.avm_address = address;
   assign done            = done_q;
   assign pass            = pass_q;
   assign id_ok           = idOk_q;
   assign ts_ok           = tsOk_q;
   assign timeout         = timeout_q;
   assign id_value        = idValue_q;
   assign ts_value        = tsValue_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: a behavioural sysid slave plus a scoreboard
// of expected check results popped when the master reports done.
module tb_sysid_check_master;

   localparam logic [31:0] ID_WORD = 32'h0000_0000;
   localparam logic [31:0] TS_WORD = 32'h5593_1994;

   typedef struct {
      string       name;
      int          lat;
      logic        pass;
      logic        idOk;
      logic        tsOk;
      logic        tmo;
      logic [31:0] idV;
      logic [31:0] tsV;
      int          idAcc;
      int          tsAcc;
   } expect_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   expect_t sb[$];
   int      total = 0;
   int      bad = 0;

   int          waitIdCfg = 0;
   bit          noValidCfg = 1'b0;
   logic [31:0] tsDataCfg = TS_WORD;
   int          waitLeft = 0;
   bit          inRead = 1'b0;
   bit          validPending = 1'b0;
   logic [31:0] pendData = '0;
   int          idAcc = 0, tsAcc = 0, idReadCycles = 0;
   int          baseIdAcc = 0, baseTsAcc = 0, baseIdCycles = 0;

   sysid_check_master_if #(.ADDR_W(1)) avmBus ();

   sysid_check_master #(
      .ADDR_W      (1),
      .BASE_WORD   (0),
      .EXPECTED_ID (ID_WORD),
      .EXPECTED_TS (TS_WORD),
      .TIMEOUT_CYC (8),
      .AUTO_START  (1'b1)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .avm      (avmBus),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .id_ok    (id_ok),
      .ts_ok    (ts_ok),
      .timeout  (timeout),
      .id_value (id_value),
      .ts_value (ts_value)
   );

   always #5 clock = ~clock;

   // Sysid slave: optional stall on the ID read, data valid one cycle after acceptance.
   always @(negedge clock) begin
      if (!reset_n) begin
         avmBus.avm_waitrequest   = 1'b0;
         avmBus.avm_readdatavalid = 1'b0;
         avmBus.avm_readdata      = '0;
         validPending             = 1'b0;
         inRead                   = 1'b0;
      end else begin
         avmBus.avm_readdatavalid = 1'b0;
         if (validPending) begin
            avmBus.avm_readdatavalid = 1'b1;
            avmBus.avm_readdata      = pendData;
            validPending             = 1'b0;
         end
         if (avmBus.avm_read) begin
            if (!inRead) begin
               inRead   = 1'b1;
               waitLeft = (avmBus.avm_address == 1'b0) ? waitIdCfg : 0;
            end
            if (avmBus.avm_address == 1'b0) idReadCycles++;
            if (waitLeft > 0) begin
               avmBus.avm_waitrequest = 1'b1;
               waitLeft--;
            end else begin
               avmBus.avm_waitrequest = 1'b0;
               inRead       = 1'b0;
               validPending = !noValidCfg;
               pendData     = (avmBus.avm_address == 1'b0) ? ID_WORD : tsDataCfg;
               if (avmBus.avm_address == 1'b0) idAcc++; else tsAcc++;
            end
         end else begin
            avmBus.avm_waitrequest = 1'b0;
         end
      end
   end

   function automatic expect_t makeExp(input string name, input int lat, input logic p,
                                       input logic io, input logic to, input logic tm,
                                       input logic [31:0] iv, input logic [31:0] tv,
                                       input int ia, input int ta);
      expect_t e;
      e.name = name; e.lat = lat; e.pass = p; e.idOk = io; e.tsOk = to; e.tmo = tm;
      e.idV = iv; e.tsV = tv; e.idAcc = ia; e.tsAcc = ta;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input expect_t e, input int waitId, input bit noValid,
                                input logic [31:0] tsData, input bit pulseStart);
      waitIdCfg    = waitId;
      noValidCfg   = noValid;
      tsDataCfg    = tsData;
      baseIdAcc    = idAcc;
      baseTsAcc    = tsAcc;
      baseIdCycles = idReadCycles;
      sb.push_back(e);
      start = pulseStart;
   endtask

   task automatic scoreResult(input bit startInTsWait);
      expect_t e;
      int      lat;
      bit      pulsed;
      e      = sb.pop_front();
      lat    = 0;
      pulsed = 1'b0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clock);
         start = 1'b0;
         if (i == 1) begin
            checkOutput({e.name, "_done_cleared"}, done, 1'b0);
            checkOutput({e.name, "_pass_cleared"}, pass, 1'b0);
         end
         if (done) begin
            lat = i;
         end else if (startInTsWait && !pulsed && busy && !avmBus.avm_read &&
                      avmBus.avm_address == 1'b1) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
      end
      checkOutput({e.name, "_done"},     done,     1'b1);
      checkOutput({e.name, "_latency"},  lat,      e.lat);
      checkOutput({e.name, "_busy"},     busy,     1'b0);
      checkOutput({e.name, "_pass"},     pass,     e.pass);
      checkOutput({e.name, "_id_ok"},    id_ok,    e.idOk);
      checkOutput({e.name, "_ts_ok"},    ts_ok,    e.tsOk);
      checkOutput({e.name, "_timeout"},  timeout,  e.tmo);
      checkOutput({e.name, "_id_value"}, id_value, e.idV);
      checkOutput({e.name, "_ts_value"}, ts_value, e.tsV);
      checkOutput({e.name, "_id_reads"}, idAcc - baseIdAcc, e.idAcc);
      checkOutput({e.name, "_ts_reads"}, tsAcc - baseTsAcc, e.tsAcc);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      checkOutput("reset_busy",    busy,                1'b0);
      checkOutput("reset_done",    done,                1'b0);
      checkOutput("reset_read",    avmBus.avm_read,     1'b0);
      checkOutput("reset_address", avmBus.avm_address,  1'b0);
      checkOutput("reset_ts_value", ts_value,           32'h0);

      reset_n = 1'b1;
      applyStimulus(makeExp("auto", 6, 1, 1, 1, 0, ID_WORD, TS_WORD, 1, 1), 0, 0, TS_WORD, 0);
      scoreResult(0);

      applyStimulus(makeExp("ts_bad", 6, 0, 1, 0, 0, ID_WORD, 32'h5593_1995, 1, 1),
                    0, 0, 32'h5593_1995, 1);
      scoreResult(0);

      applyStimulus(makeExp("stall", 9, 1, 1, 1, 0, ID_WORD, TS_WORD, 1, 1), 3, 0, TS_WORD, 1);
      scoreResult(0);
      checkOutput("stall_id_req_cycles", idReadCycles - baseIdCycles, 4);

      applyStimulus(makeExp("tmo", 10, 0, 0, 0, 1, 32'h0, 32'h0, 1, 0), 0, 1, TS_WORD, 1);
      scoreResult(0);

      applyStimulus(makeExp("start_busy", 6, 1, 1, 1, 0, ID_WORD, TS_WORD, 1, 1), 0, 0, TS_WORD, 1);
      scoreResult(1);
      repeat (8) @(negedge clock);
      checkOutput("start_busy_idle",   busy,              1'b0);
      checkOutput("start_busy_single", idAcc - baseIdAcc, 1);

      applyStimulus(makeExp("restart", 6, 1, 1, 1, 0, ID_WORD, TS_WORD, 1, 1), 0, 0, TS_WORD, 1);
      scoreResult(0);

      waitIdCfg = 20;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      checkOutput("rst_pre_read", avmBus.avm_read, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("rst_read_drop", avmBus.avm_read, 1'b0);
      checkOutput("rst_busy",      busy,            1'b0);
      checkOutput("rst_done",      done,            1'b0);
      checkOutput("rst_id_ok",     id_ok,           1'b0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(makeExp("rerun", 6, 1, 1, 1, 0, ID_WORD, TS_WORD, 1, 1), 0, 0, TS_WORD, 0);
      scoreResult(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
